// File: rtl/dff_counter.sv
// dff_counter: WIDTH-bit register with hold/load/increment/decrement modes, a registered wrap flag and zero detect.
// Define DFF_COUNTER_SAT_EN to saturate at all-ones/zero instead of wrapping around.
module dff_counter #(
  parameter int WIDTH       = 12,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             wrap,
  output logic             zero
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_INC  = 2'b10,
    MODE_DEC  = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextWrap;
  mode_t            w_mode;

  assign w_mode = mode_t'(mode);

  // wrap is recomputed on every enabled arithmetic step, so it clears on the first non-overflowing update
  always_comb begin
    w_nextQ    = r_q;
    w_nextWrap = r_wrap;
    if (en) begin
      case (w_mode)
        MODE_HOLD: begin
          w_nextQ    = r_q;
          w_nextWrap = r_wrap;
        end
        MODE_LOAD: begin
          w_nextQ    = d;
          w_nextWrap = 1'b0;
        end
        MODE_INC: begin
          w_nextWrap = (r_q == ALL_ONES);
`ifdef DFF_COUNTER_SAT_EN
          w_nextQ    = (r_q == ALL_ONES) ? r_q : r_q + ONE;
`else
          w_nextQ    = r_q + ONE;
`endif
        end
        MODE_DEC: begin
          w_nextWrap = (r_q == '0);
`ifdef DFF_COUNTER_SAT_EN
          w_nextQ    = (r_q == '0) ? r_q : r_q - ONE;
`else
          w_nextQ    = r_q - ONE;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q    <= RST_Q;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_nextQ;
      r_wrap <= w_nextWrap;
    end
  end

  assign q    = r_q;
  assign nq   = ~r_q;
  assign wrap = r_wrap;
  assign zero = (r_q == '0);

endmodule

// File: tb/tb_dff_counter.sv
// Scoreboard bench for dff_counter: directed vectors on a 12-bit instance plus free-running
// sweeps of 2- and 16-bit instances. Follows DFF_COUNTER_SAT_EN when it is defined.
module tb_dff_counter;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] d = 12'h000;
  logic [11:0] q, nq;
  logic        wrap, zero;

  logic        clrSweep = 1'b0;
  logic        enSweep = 1'b1;
  logic [1:0]  modeSweep = 2'b10;
  logic [1:0]  d2 = 2'b00;
  logic [15:0] d16 = 16'h0000;
  logic [1:0]  q2, nq2;
  logic [15:0] q16, nq16;
  logic        wrap2, zero2, wrap16, zero16;

  typedef struct {
    string       name;
    logic [11:0] q;
    logic        wrap;
    logic        zero;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  event sampleEv;
  bit   mainDone = 1'b0;

`ifdef DFF_COUNTER_SAT_EN
  localparam logic [11:0] INC2_Q = 12'hFFF;
  localparam logic        INC2_Z = 1'b0;
  localparam logic [11:0] INC3_Q = 12'hFFF;
  localparam logic        INC3_W = 1'b1;
  localparam logic [11:0] DEC2_Q = 12'h000;
  localparam logic        DEC2_Z = 1'b1;
  localparam logic [1:0]  B2B_MODE = 2'b11;
  localparam int          WRAPS2 = 65534;
  localparam int          WRAPS16 = 2;
`else
  localparam logic [11:0] INC2_Q = 12'h000;
  localparam logic        INC2_Z = 1'b1;
  localparam logic [11:0] INC3_Q = 12'h001;
  localparam logic        INC3_W = 1'b0;
  localparam logic [11:0] DEC2_Q = 12'hFFF;
  localparam logic        DEC2_Z = 1'b0;
  localparam logic [1:0]  B2B_MODE = 2'b10;
  localparam int          WRAPS2 = 16384;
  localparam int          WRAPS16 = 1;
`endif

  dff_counter #(.WIDTH(12), .RESET_VALUE(12'h005)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d),
    .q(q), .nq(nq), .wrap(wrap), .zero(zero)
  );

  dff_counter #(.WIDTH(2), .RESET_VALUE(0)) dut2 (
    .clk(clk), .clr(clrSweep), .en(enSweep), .mode(modeSweep), .d(d2),
    .q(q2), .nq(nq2), .wrap(wrap2), .zero(zero2)
  );

  dff_counter #(.WIDTH(16), .RESET_VALUE(0)) dut16 (
    .clk(clk), .clr(clrSweep), .en(enSweep), .mode(modeSweep), .d(d16),
    .q(q16), .nq(nq16), .wrap(wrap16), .zero(zero16)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector just after a falling edge; the monitor checks it at the following falling edge
  task automatic applyStimulus(input string name, input logic c, input logic e, input logic [1:0] m,
                               input logic [11:0] dv, input logic [11:0] eq, input logic ew,
                               input logic ez);
    exp_t x;
    @(negedge clk);
    #1;
    clr  = c;
    en   = e;
    mode = m;
    d    = dv;
    x = '{name: name, q: eq, wrap: ew, zero: ez};
    expQ.push_back(x);
  endtask

  // Assert clr between edges with an increment pending and sample before the next edge arrives
  task automatic applyAsyncReset(input string name);
    exp_t x;
    @(negedge clk);
    #1;
    clr  = 1'b0;
    en   = 1'b1;
    mode = 2'b10;
    #2;
    clr = 1'b1;
    x = '{name: name, q: 12'h005, wrap: 1'b0, zero: 1'b0};
    expQ.push_back(x);
    #1;
    ->sampleEv;
  endtask

  // Release clr right at a rising edge; that edge must leave the reset value in place
  task automatic applyReleaseAtEdge(input string name);
    exp_t x;
    @(posedge clk);
    #1;
    clr = 1'b0;
    x = '{name: name, q: 12'h005, wrap: 1'b0, zero: 1'b0};
    expQ.push_back(x);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [11:0] expNq;
    forever begin
      @(negedge clk or sampleEv);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        expNq = ~e.q;
        checkOutput({e.name, " q"}, 32'(q), 32'(e.q));
        checkOutput({e.name, " nq"}, 32'(nq), 32'(expNq));
        checkOutput({e.name, " wrap"}, 32'(wrap), 32'(e.wrap));
        checkOutput({e.name, " zero"}, 32'(zero), 32'(e.zero));
      end
    end
  end

  initial begin : stimulus
    #1;
    clr = 1'b1;
    clrSweep = 1'b1;
    applyStimulus("reset hold1", 1'b1, 1'b1, 2'b10, 12'h000, 12'h005, 1'b0, 1'b0);
    applyStimulus("reset hold2", 1'b1, 1'b1, 2'b10, 12'h000, 12'h005, 1'b0, 1'b0);
    applyStimulus("reset release", 1'b0, 1'b1, 2'b10, 12'h000, 12'h006, 1'b0, 1'b0);
    applyStimulus("load ABC", 1'b0, 1'b1, 2'b01, 12'hABC, 12'hABC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("en low hold", 1'b0, 1'b0, 2'b10, 12'h123, 12'hABC, 1'b0, 1'b0);
    applyStimulus("mode00 hold", 1'b0, 1'b1, 2'b00, 12'h123, 12'hABC, 1'b0, 1'b0);
    applyStimulus("load FFE", 1'b0, 1'b1, 2'b01, 12'hFFE, 12'hFFE, 1'b0, 1'b0);
    applyStimulus("inc1", 1'b0, 1'b1, 2'b10, 12'h000, 12'hFFF, 1'b0, 1'b0);
    applyStimulus("inc2", 1'b0, 1'b1, 2'b10, 12'h000, INC2_Q, 1'b1, INC2_Z);
    applyStimulus("inc3", 1'b0, 1'b1, 2'b10, 12'h000, INC3_Q, INC3_W, 1'b0);
    applyStimulus("load 001", 1'b0, 1'b1, 2'b01, 12'h001, 12'h001, 1'b0, 1'b0);
    applyStimulus("dec1", 1'b0, 1'b1, 2'b11, 12'h000, 12'h000, 1'b0, 1'b1);
    applyStimulus("dec2", 1'b0, 1'b1, 2'b11, 12'h000, DEC2_Q, 1'b1, DEC2_Z);
    applyStimulus("wrap hold", 1'b0, 1'b0, 2'b10, 12'h000, DEC2_Q, 1'b1, DEC2_Z);
    applyStimulus("back to back wrap", 1'b0, 1'b1, B2B_MODE, 12'h000, 12'h000, 1'b1, 1'b1);
    applyAsyncReset("async clr after wrap");
    applyReleaseAtEdge("release at edge a");
    applyStimulus("inc after release a", 1'b0, 1'b1, 2'b10, 12'h000, 12'h006, 1'b0, 1'b0);
    applyStimulus("load 010", 1'b0, 1'b1, 2'b01, 12'h010, 12'h010, 1'b0, 1'b0);
    applyStimulus("inc from 010", 1'b0, 1'b1, 2'b10, 12'h000, 12'h011, 1'b0, 1'b0);
    applyAsyncReset("async clr mid count");
    applyReleaseAtEdge("release at edge b");
    applyStimulus("inc after release b", 1'b0, 1'b1, 2'b10, 12'h000, 12'h006, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    mainDone = 1'b1;
  end

  // Free-running increment on the 2- and 16-bit instances against a small reference model
  initial begin : sweep
    logic [1:0]  m2;
    logic [15:0] m16;
    logic        w2m, w16m;
    int          bad2, bad16, wraps2, wraps16;
    bad2 = 0;
    bad16 = 0;
    wraps2 = 0;
    wraps16 = 0;
    m2 = 2'b00;
    m16 = 16'h0000;
    wait (mainDone);
    @(negedge clk);
    clrSweep = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      w2m = (m2 == 2'b11);
      w16m = (m16 == 16'hFFFF);
`ifdef DFF_COUNTER_SAT_EN
      if (!w2m) m2 = m2 + 2'd1;
      if (!w16m) m16 = m16 + 16'd1;
`else
      m2 = m2 + 2'd1;
      m16 = m16 + 16'd1;
`endif
      if (q2 !== m2 || wrap2 !== w2m || (nq2 ^ q2) !== 2'b11 || zero2 !== (m2 == 2'b00))
        bad2++;
      if (q16 !== m16 || wrap16 !== w16m || (nq16 ^ q16) !== 16'hFFFF || zero16 !== (m16 == 16'h0000))
        bad16++;
      if (wrap2 === 1'b1) wraps2++;
      if (wrap16 === 1'b1) wraps16++;
    end
    checkOutput("sweep w2 model cycles off", 32'(bad2), 32'd0);
    checkOutput("sweep w16 model cycles off", 32'(bad16), 32'd0);
    checkOutput("sweep w2 wrap count", 32'(wraps2), 32'(WRAPS2));
    checkOutput("sweep w16 wrap count", 32'(wraps16), 32'(WRAPS16));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
